// File: rtl/tlb_miss_ctrl_pkg.sv
// Shared constants and types for the TLB miss sequencer.
// Contents: geometry (ways, sets, index/way widths), page field widths,
// fault codes, FSM state encoding, and the request payload struct.
package tlb_miss_ctrl_pkg;

    localparam int unsigned NUM_WAYS       = 4;
    localparam int unsigned WAY_BITS       = $clog2(NUM_WAYS);
    localparam int unsigned SET_INDEX_BITS = 4;
    localparam int unsigned NUM_SETS       = 1 << SET_INDEX_BITS;
    localparam int unsigned VPN_BITS       = 20;
    localparam int unsigned PPN_BITS       = 20;

    localparam logic [1:0] FAULT_OK   = 2'b00;
    localparam logic [1:0] FAULT_PERM = 2'b01;
    localparam logic [1:0] FAULT_PAGE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WALK_REQ  = 3'd2,
        ST_WALK_WAIT = 3'd3,
        ST_FILL      = 3'd4,
        ST_RESP      = 3'd5
    } state_t;

    // Translation request as seen after arbitration.
    typedef struct packed {
        logic        id;
        logic        acc_type;
        logic [31:0] vaddr;
    } req_t;

    // Set index field of a virtual address.
    function automatic logic [SET_INDEX_BITS-1:0] set_of(input logic [31:0] va);
        return va[SET_INDEX_BITS+11:12];
    endfunction

endpackage

// File: rtl/tlb_rr_arb.sv
// Two-input round-robin arbiter; the requester granted last loses a tie.
// Ports: clk, rst (async, active-high), valid[1:0] requests,
//        advance (grant is consumed this cycle), grant[1:0] one-hot grant.
module tlb_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    // Last granted requester; reset to 1 so req0 wins the first tie.
    logic last;

    always_comb begin
        grant = 2'b00;
        if (valid[0] && (!valid[1] || last)) begin
            grant[0] = 1'b1;
        end else if (valid[1]) begin
            grant[1] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/tlb_miss_ctrl.sv
// TLB miss sequencer: arbitrates fetch/ld-st requests, drives one lookup at
// a time, runs the page walk and refill on a miss, then re-looks-up and
// returns {ppn, offset} with a fault code.
// Ports: req0_*/req1_* request ports (ready is combinational, IDLE only);
//        lk_* lookup address out / hit result in; walk_req_*/walk_resp_*
//        walker handshake; fill_* one-cycle TLB write; resp_* one-cycle
//        response pulse.
// Build option: TLB_PERF_CNT_EN adds hit_cnt / miss_cnt outputs.
module tlb_miss_ctrl
    import tlb_miss_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0_valid,
    input  logic [31:0]               req0_vaddr,
    input  logic                      req0_type,
    output logic                      req0_ready,
    input  logic                      req1_valid,
    input  logic [31:0]               req1_vaddr,
    input  logic                      req1_type,
    output logic                      req1_ready,
    output logic [31:0]               lk_vaddr,
    output logic                      lk_access_type,
    input  logic                      lk_hit,
    input  logic [PPN_BITS-1:0]       lk_ppn,
    input  logic                      lk_perm_fault,
    output logic                      walk_req_valid,
    output logic [VPN_BITS-1:0]       walk_req_vpn,
    input  logic                      walk_req_ready,
    input  logic                      walk_resp_valid,
    input  logic [PPN_BITS-1:0]       walk_resp_ppn,
    input  logic [1:0]                walk_resp_perms,
    input  logic                      walk_resp_fault,
    output logic                      fill_en,
    output logic [SET_INDEX_BITS-1:0] fill_set,
    output logic [WAY_BITS-1:0]       fill_way,
    output logic [VPN_BITS-1:0]       fill_vpn,
    output logic [PPN_BITS-1:0]       fill_ppn,
    output logic [1:0]                fill_perms,
    output logic                      resp_valid,
    output logic                      resp_id,
    output logic [31:0]               resp_paddr,
    output logic [1:0]                resp_fault
`ifdef TLB_PERF_CNT_EN
    ,
    output logic [31:0]               hit_cnt,
    output logic [31:0]               miss_cnt
`endif
);

    state_t                              state;
    logic [1:0]                          grant;
    req_t                                req_sel;
    logic                                req_id_q;
    logic                                relookup_q;
    logic [NUM_SETS-1:0][WAY_BITS-1:0]   victim_ptr;
    logic [SET_INDEX_BITS-1:0]           cur_set;

    tlb_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   ({req1_valid, req0_valid}),
        .advance (state == ST_IDLE),
        .grant   (grant)
    );

    assign req0_ready = (state == ST_IDLE) && grant[0];
    assign req1_ready = (state == ST_IDLE) && grant[1];
    assign cur_set    = set_of(lk_vaddr);

    // Payload of the granted requester.
    always_comb begin
        req_sel          = '0;
        req_sel.id       = grant[1];
        req_sel.acc_type = grant[1] ? req1_type  : req0_type;
        req_sel.vaddr    = grant[1] ? req1_vaddr : req0_vaddr;
    end

    // Sequencer; lk_vaddr doubles as the registered request address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            req_id_q       <= 1'b0;
            relookup_q     <= 1'b0;
            victim_ptr     <= '0;
            lk_vaddr       <= '0;
            lk_access_type <= 1'b0;
            walk_req_valid <= 1'b0;
            walk_req_vpn   <= '0;
            fill_en        <= 1'b0;
            fill_set       <= '0;
            fill_way       <= '0;
            fill_vpn       <= '0;
            fill_ppn       <= '0;
            fill_perms     <= '0;
            resp_valid     <= 1'b0;
            resp_id        <= 1'b0;
            resp_paddr     <= '0;
            resp_fault     <= FAULT_OK;
`ifdef TLB_PERF_CNT_EN
            hit_cnt        <= '0;
            miss_cnt       <= '0;
`endif
        end else begin
            fill_en    <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_paddr <= '0;
            resp_fault <= FAULT_OK;
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        req_id_q       <= req_sel.id;
                        lk_vaddr       <= req_sel.vaddr;
                        lk_access_type <= req_sel.acc_type;
                        relookup_q     <= 1'b0;
                        state          <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (lk_hit) begin
                        resp_valid <= 1'b1;
                        resp_id    <= req_id_q;
                        resp_paddr <= {lk_ppn, lk_vaddr[11:0]};
                        resp_fault <= lk_perm_fault ? FAULT_PERM : FAULT_OK;
                        state      <= ST_RESP;
`ifdef TLB_PERF_CNT_EN
                        if (!relookup_q) begin
                            hit_cnt <= hit_cnt + 32'd1;
                        end
`endif
                    end else begin
                        walk_req_valid <= 1'b1;
                        walk_req_vpn   <= lk_vaddr[31:12];
                        state          <= ST_WALK_REQ;
`ifdef TLB_PERF_CNT_EN
                        miss_cnt       <= miss_cnt + 32'd1;
`endif
                    end
                end
                ST_WALK_REQ: begin
                    if (walk_req_ready) begin
                        walk_req_valid <= 1'b0;
                        walk_req_vpn   <= '0;
                        state          <= ST_WALK_WAIT;
                    end
                end
                ST_WALK_WAIT: begin
                    if (walk_resp_valid) begin
                        if (walk_resp_fault) begin
                            resp_valid <= 1'b1;
                            resp_id    <= req_id_q;
                            resp_paddr <= '0;
                            resp_fault <= FAULT_PAGE;
                            state      <= ST_RESP;
                        end else begin
                            fill_en    <= 1'b1;
                            fill_set   <= cur_set;
                            fill_way   <= victim_ptr[cur_set];
                            fill_vpn   <= lk_vaddr[31:12];
                            fill_ppn   <= walk_resp_ppn;
                            fill_perms <= walk_resp_perms;
                            state      <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    // Two-bit pointer wraps 3 -> 0 naturally.
                    victim_ptr[fill_set] <= victim_ptr[fill_set] + WAY_BITS'(1);
                    relookup_q           <= 1'b1;
                    state                <= ST_LOOKUP;
                end
                ST_RESP: begin
                    lk_vaddr       <= '0;
                    lk_access_type <= 1'b0;
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_miss_ctrl.sv
// Bench for tlb_miss_ctrl: models TLB storage/lookup, a page table walker,
// and a transaction-level expectation of each accepted request.
module tb_tlb_miss_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_type, req1_valid, req1_type;
    logic [31:0] req0_vaddr, req1_vaddr;
    logic        req0_ready, req1_ready;
    logic [31:0] lk_vaddr;
    logic        lk_access_type, lk_hit, lk_perm_fault;
    logic [19:0] lk_ppn;
    logic        walk_req_valid, walk_req_ready, walk_resp_valid, walk_resp_fault;
    logic [19:0] walk_req_vpn, walk_resp_ppn;
    logic [1:0]  walk_resp_perms;
    logic        fill_en;
    logic [3:0]  fill_set;
    logic [1:0]  fill_way, fill_perms;
    logic [19:0] fill_vpn, fill_ppn;
    logic        resp_valid, resp_id;
    logic [31:0] resp_paddr;
    logic [1:0]  resp_fault;
`ifdef TLB_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    tlb_miss_ctrl dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_vaddr(req0_vaddr), .req0_type(req0_type), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_vaddr(req1_vaddr), .req1_type(req1_type), .req1_ready(req1_ready),
        .lk_vaddr(lk_vaddr), .lk_access_type(lk_access_type),
        .lk_hit(lk_hit), .lk_ppn(lk_ppn), .lk_perm_fault(lk_perm_fault),
        .walk_req_valid(walk_req_valid), .walk_req_vpn(walk_req_vpn), .walk_req_ready(walk_req_ready),
        .walk_resp_valid(walk_resp_valid), .walk_resp_ppn(walk_resp_ppn),
        .walk_resp_perms(walk_resp_perms), .walk_resp_fault(walk_resp_fault),
        .fill_en(fill_en), .fill_set(fill_set), .fill_way(fill_way),
        .fill_vpn(fill_vpn), .fill_ppn(fill_ppn), .fill_perms(fill_perms),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_paddr(resp_paddr), .resp_fault(resp_fault)
`ifdef TLB_PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    // TLB storage seen by the lookup port
    logic        tv    [16][4];
    logic [19:0] tvpn  [16][4];
    logic [19:0] tppn  [16][4];
    logic [1:0]  tperm [16][4];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Page table behind the walker
    function automatic void pt(input logic [19:0] vpn, output logic [19:0] ppn,
                               output logic [1:0] perm, output logic flt);
        flt = 1'b0; ppn = '0; perm = '0;
        if (vpn == 20'h00400) begin ppn = 20'h00077; perm = 2'b01; end
        else if (vpn == 20'h00888) begin ppn = 20'h00123; perm = 2'b11; end
        else if (vpn[3:0] == 4'h3 && vpn[19:16] != 4'h0) begin ppn = vpn + 20'h00100; perm = 2'b11; end
        else flt = 1'b1;
    endfunction

    function automatic logic perm_bad(input logic [1:0] p, input logic wr);
        return wr ? !p[1] : !p[0];
    endfunction

    // Transaction model state
    logic        m_busy = 1'b0, m_last = 1'b1;
    int          m_accept_cyc = 0, m_fills = 0, cyc = 0;
    logic        m_id, m_type, m_hit, m_pfault, m_fill_exp;
    logic [31:0] m_va, m_exp_paddr;
    logic [1:0]  m_exp_fault, m_perm;
    logic [19:0] m_ppn;
    logic [1:0]  m_vptr [16];
    int          m_hits = 0, m_miss = 0;
    int          n_resp = 0, n_fill = 0, n_walk = 0, last_lat = 0;
    logic [31:0] last_paddr;
    logic [1:0]  last_fault;
    logic        last_id;
    int          grant_log[$];
    int          way_log[$];
    int          walk_delay = 3;
    int          walk_st = 0;

    // Compare process plus lookup-port environment
    initial begin
        logic busy0, er0, er1;
        logic [3:0] s;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                check("rst_ctl", {req0_ready, req1_ready, walk_req_valid, fill_en, resp_valid,
                                  resp_id, lk_access_type, resp_fault}, '0);
                check("rst_data", {lk_vaddr, resp_paddr}, '0);
                check("rst_walk", walk_req_vpn, '0);
                m_busy = 1'b0; m_last = 1'b1; m_hits = 0; m_miss = 0;
                foreach (m_vptr[i]) m_vptr[i] = '0;
            end else begin
                busy0 = m_busy;
                er0 = !busy0 && req0_valid && (!req1_valid || m_last);
                er1 = !busy0 && req1_valid && !er0;
                check("ready", {req0_ready, req1_ready}, {er0, er1});
                check("lk_drive", {lk_access_type, lk_vaddr}, busy0 ? {m_type, m_va} : 33'd0);
                if (!busy0 || m_hit) check("no_walk", walk_req_valid, 1'b0);
                else if (walk_req_valid) check("walk_vpn", walk_req_vpn, m_va[31:12]);
                if (!busy0 || !m_fill_exp || m_fills != 0) check("no_fill", fill_en, 1'b0);
                else if (fill_en) begin
                    s = m_va[15:12];
                    check("fill", {fill_set, fill_way, fill_vpn, fill_ppn, fill_perms},
                          {s, m_vptr[s], m_va[31:12], m_ppn, m_perm});
                    way_log.push_back(int'(m_vptr[s]));
                    tv[s][m_vptr[s]]    = 1'b1;
                    tvpn[s][m_vptr[s]]  = m_va[31:12];
                    tppn[s][m_vptr[s]]  = m_ppn;
                    tperm[s][m_vptr[s]] = m_perm;
                    m_vptr[s] = m_vptr[s] + 2'd1;
                    m_fills++; n_fill++;
                end
                if (!busy0) check("no_resp", resp_valid, 1'b0);
                else if (resp_valid) begin
                    check("resp", {resp_id, resp_fault, resp_paddr}, {m_id, m_exp_fault, m_exp_paddr});
                    check("resp_fills", m_fills, m_fill_exp ? 1 : 0);
                    if (m_hit) check("hit_latency", cyc - m_accept_cyc, 2);
                    last_paddr = resp_paddr; last_fault = resp_fault; last_id = resp_id;
                    last_lat = cyc - m_accept_cyc;
                    n_resp++;
                    m_busy = 1'b0;
                end
                if (!resp_valid) check("resp_quiet", {resp_id, resp_fault, resp_paddr}, '0);
                if (m_busy && cyc - m_accept_cyc > 300) begin
                    check("txn_bound", m_busy, 1'b0);
                    m_busy = 1'b0;
                end
                if (er0 || er1) begin
                    m_id   = er1;
                    m_va   = er1 ? req1_vaddr : req0_vaddr;
                    m_type = er1 ? req1_type : req0_type;
                    m_last = er1;
                    grant_log.push_back(er1 ? 1 : 0);
                    m_accept_cyc = cyc; m_fills = 0; m_busy = 1'b1;
                    s = m_va[15:12]; m_hit = 1'b0; m_pfault = 1'b0;
                    for (int w = 0; w < 4; w++)
                        if (tv[s][w] && tvpn[s][w] == m_va[31:12]) begin
                            m_hit = 1'b1; m_ppn = tppn[s][w]; m_perm = tperm[s][w];
                        end
                    if (!m_hit) pt(m_va[31:12], m_ppn, m_perm, m_pfault);
                    if (m_hit) m_hits++; else m_miss++;
                    m_fill_exp  = !m_hit && !m_pfault;
                    m_exp_paddr = m_pfault ? 32'd0 : {m_ppn, m_va[11:0]};
                    m_exp_fault = m_pfault ? 2'b10 : (perm_bad(m_perm, m_type) ? 2'b01 : 2'b00);
                end
            end
            lk_hit = 1'b0; lk_ppn = '0; lk_perm_fault = 1'b0;
            for (int w = 0; w < 4; w++)
                if (tv[lk_vaddr[15:12]][w] && tvpn[lk_vaddr[15:12]][w] == lk_vaddr[31:12]) begin
                    lk_hit = 1'b1;
                    lk_ppn = tppn[lk_vaddr[15:12]][w];
                    lk_perm_fault = perm_bad(tperm[lk_vaddr[15:12]][w], lk_access_type);
                end
        end
    end

    // Walker: accepts after 2 cycles, answers walk_delay cycles later; ignores rst
    initial begin
        int cnt;
        logic [19:0] vpn_l;
        cnt = 0; vpn_l = '0;
        forever begin
            @(negedge clk);
            case (walk_st)
                0: if (walk_req_valid) begin cnt = 2; walk_st = 1; end
                1: if (cnt == 0) begin walk_req_ready = 1'b1; vpn_l = walk_req_vpn; walk_st = 2; end
                   else cnt--;
                2: begin walk_req_ready = 1'b0; n_walk++; cnt = walk_delay; walk_st = 3; end
                3: if (cnt == 0) begin
                       pt(vpn_l, walk_resp_ppn, walk_resp_perms, walk_resp_fault);
                       walk_resp_valid = 1'b1; walk_st = 4;
                   end else cnt--;
                default: begin
                    walk_resp_valid = 1'b0; walk_resp_ppn = '0; walk_resp_perms = '0;
                    walk_resp_fault = 1'b0; walk_st = 0;
                end
            endcase
        end
    end

    task automatic send_req(input int port, input logic [31:0] va, input logic t);
        int n;
        logic acc;
        n = 0; acc = 1'b0;
        if (port == 0) begin req0_valid = 1'b1; req0_vaddr = va; req0_type = t; end
        else begin req1_valid = 1'b1; req1_vaddr = va; req1_type = t; end
        while (!acc && n < 400) begin
            @(negedge clk);
            n++;
            acc = (port == 0) ? req0_ready : req1_ready;
        end
        check("accept_bound", acc, 1'b1);
        @(posedge clk); #1;
        if (port == 0) begin req0_valid = 1'b0; req0_vaddr = '0; req0_type = 1'b0; end
        else begin req1_valid = 1'b0; req1_vaddr = '0; req1_type = 1'b0; end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (m_busy && n < 400) begin @(posedge clk); n++; end
        check("done_bound", m_busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int g0, w0, nf, nr, n;
        rst = 1'b1;
        req0_valid = 0; req0_vaddr = 0; req0_type = 0;
        req1_valid = 0; req1_vaddr = 0; req1_type = 0;
        lk_hit = 0; lk_ppn = 0; lk_perm_fault = 0;
        walk_req_ready = 0; walk_resp_valid = 0; walk_resp_ppn = 0;
        walk_resp_perms = 0; walk_resp_fault = 0;
        for (int i = 0; i < 16; i++)
            for (int w = 0; w < 4; w++) begin
                tv[i][w] = 0; tvpn[i][w] = 0; tppn[i][w] = 0; tperm[i][w] = 0;
            end
        tv[5][0] = 1; tvpn[5][0] = 20'h12345; tppn[5][0] = 20'hABCDE; tperm[5][0] = 2'b11;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: preloaded hit
        send_req(0, 32'h12345678, 1'b0);
        wait_done();
        check("s1_paddr", last_paddr, 32'hABCDE678);
        check("s1_fault_id", {last_fault, last_id}, 3'b000);
        check("s1_latency", last_lat, 2);
        check("s1_no_walk", n_walk, 0);

        // 2: miss, walk, fill, re-lookup
        send_req(1, 32'h00400010, 1'b0);
        wait_done();
        check("s2_paddr", last_paddr, 32'h00077010);
        check("s2_fault_id", {last_fault, last_id}, 3'b001);
        check("s2_fills", n_fill, 1);
        check("s2_way", way_log[0], 0);
`ifdef TLB_PERF_CNT_EN
        check("s2_hit_cnt", hit_cnt, 32'd1);
        check("s2_miss_cnt", miss_cnt, 32'd1);
`endif

        // 3: write to read-only page
        send_req(0, 32'h00400010, 1'b1);
        wait_done();
        check("s3_paddr", last_paddr, 32'h00077010);
        check("s3_fault", last_fault, 2'b01);
        check("s3_walks", n_walk, 1);

        // 4: walk returns page fault
        send_req(1, 32'h00999000, 1'b0);
        wait_done();
        check("s4_paddr", last_paddr, 32'd0);
        check("s4_fault", last_fault, 2'b10);
        check("s4_fills", n_fill, 1);

        // 5: both requesters busy, five misses to set 3
        g0 = grant_log.size(); w0 = way_log.size();
        fork
            begin
                send_req(0, 32'h10003000, 1'b0);
                send_req(0, 32'h30003000, 1'b0);
                send_req(0, 32'h50003000, 1'b0);
            end
            begin
                send_req(1, 32'h20003004, 1'b0);
                send_req(1, 32'h40003008, 1'b0);
            end
        join
        wait_done();
        check("s5_grants", grant_log.size() - g0, 5);
        check("s5_ways", way_log.size() - w0, 5);
        if (grant_log.size() - g0 == 5 && way_log.size() - w0 == 5) begin
            check("s5_grant_seq", {grant_log[g0], grant_log[g0+1], grant_log[g0+2],
                                   grant_log[g0+3], grant_log[g0+4]}, {32'd0, 32'd1, 32'd0, 32'd1, 32'd0});
            check("s5_way_seq", {way_log[w0][1:0], way_log[w0+1][1:0], way_log[w0+2][1:0],
                                 way_log[w0+3][1:0], way_log[w0+4][1:0]}, 10'b00_01_10_11_00);
        end

        // 6: reset while the walk is outstanding, late walk response
        walk_delay = 10;
        nf = n_fill; nr = n_resp;
        send_req(0, 32'h00888010, 1'b0);
        n = 0;
        while (walk_st != 3 && n < 200) begin @(posedge clk); n++; end
        check("s6_walk_pending", walk_st, 3);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("s6_no_fill", n_fill, nf);
        check("s6_no_resp", n_resp, nr);
        send_req(0, 32'h12345ABC, 1'b0);
        wait_done();
        check("s6_paddr", last_paddr, 32'hABCDEABC);
        check("s6_fault_id", {last_fault, last_id}, 3'b000);
`ifdef TLB_PERF_CNT_EN
        check("end_hit_cnt", hit_cnt, m_hits);
        check("end_miss_cnt", miss_cnt, m_miss);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
